// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types and helpers for the EX operand-forwarding / hazard controller.
// Holds mux-select encodings, FSM state enum, scoreboard slot struct.
package hazard_forward_ctrl_pkg;

    localparam int unsigned DST_W = 5;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [DST_W-1:0] dst;
        logic             reg_write;
        logic             mem_read;
    } sb_slot_t;

    // Slot produces a GPR that the ID source actually reads; $0 never matches.
    function automatic logic slot_hits(
        input sb_slot_t         s,
        input logic [DST_W-1:0] src,
        input logic             used
    );
        return used && s.valid && s.reg_write &&
               (s.dst != '0) && (s.dst == src);
    endfunction

    // Newest producer wins; a load still in EX cannot forward from MEM.
    function automatic logic [1:0] fwd_sel(
        input sb_slot_t         ex,
        input sb_slot_t         mem,
        input logic [DST_W-1:0] src,
        input logic             used
    );
        if (slot_hits(ex, src, used) && !ex.mem_read) return FWD_MEM;
        if (slot_hits(mem, src, used)) return FWD_WB;
        return FWD_REGFILE;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight destination tracker: shift register of ID->EX->MEM slots.
// Ports: clk_i, rst_i, hold_i (freeze), bubble_i (NOP into EX), id_slot_i, ex_o, mem_o.
module hazard_scoreboard
    import hazard_forward_ctrl_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     hold_i,
    input  logic     bubble_i,
    input  sb_slot_t id_slot_i,
    output sb_slot_t ex_o,
    output sb_slot_t mem_o
);

    sb_slot_t ex_q, ex_d;
    sb_slot_t mem_q, mem_d;

    // The WB-stage producer is covered by write-before-read in the
    // register file, so it drops out of the tracker when it leaves MEM.
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        if (!hold_i) begin
            mem_d = ex_q;
            ex_d  = bubble_i ? '0 : id_slot_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
        end
    end

    assign ex_o  = ex_q;
    assign mem_o = mem_q;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Forwarding-select, load-use stall and branch-flush controller for EX.
// Ports: ID instruction fields, branch_taken, ext_stall in; mux selects,
//        PC/IF-ID enables, flush/bubble and stall/flush counters out.
module hazard_forward_ctrl
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [DST_W-1:0] id_rs,
    input  logic [DST_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [DST_W-1:0] id_dst,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             branch_taken,
    input  logic             ext_stall,
    output logic [1:0]       forward_a_sel,
    output logic [1:0]       forward_b_sel,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    sb_slot_t   id_slot, ex_slot, mem_slot;
    state_e     state_q, state_d;
    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic load_use, stall_evt, flush_evt;

    assign id_slot = '{valid:     id_valid,
                       dst:       id_dst,
                       reg_write: id_reg_write,
                       mem_read:  id_mem_read};

    hazard_scoreboard u_sb (
        .clk_i     (clk),
        .rst_i     (rst),
        .hold_i    (ext_stall),
        .bubble_i  (idex_bubble),
        .id_slot_i (id_slot),
        .ex_o      (ex_slot),
        .mem_o     (mem_slot)
    );

    assign load_use = id_valid && ex_slot.mem_read &&
                      (slot_hits(ex_slot, id_rs, id_uses_rs) ||
                       slot_hits(ex_slot, id_rt, id_uses_rt));

    assign flush_evt = !ext_stall && branch_taken;
    assign stall_evt = !ext_stall && !branch_taken && load_use;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (ext_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_comb begin
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (!ext_stall) begin
            if (idex_bubble) begin
                fwd_a_d = FWD_REGFILE;
                fwd_b_d = FWD_REGFILE;
            end else begin
                fwd_a_d = fwd_sel(ex_slot, mem_slot, id_rs,
                                  id_valid && id_uses_rs);
                fwd_b_d = fwd_sel(ex_slot, mem_slot, id_rt,
                                  id_valid && id_uses_rt);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (!ext_stall) begin
            unique case (state_q)
                STALL:   state_d = RUN;
                default: begin
                    if (branch_taken)  state_d = FLUSH;
                    else if (load_use) state_d = STALL;
                    else               state_d = RUN;
                end
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_evt && stall_q != '1) stall_d = stall_q + CNT_ONE;
        if (flush_evt && flush_q != '1) flush_d = flush_q + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            fwd_a_q <= FWD_REGFILE;
            fwd_b_q <= FWD_REGFILE;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign forward_a_sel = fwd_a_q;
    assign forward_b_sel = fwd_b_q;
    assign stall_cycles  = stall_q;
    assign flush_cycles  = flush_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: forwarding, load-use, flush,
// $0, ext_stall freeze, reset mid-stall and counter saturation.
module tb_hazard_forward_ctrl;

    localparam int unsigned CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [4:0]       id_rs, id_rt, id_dst;
    logic             id_uses_rs, id_uses_rt;
    logic             id_reg_write, id_mem_read;
    logic             branch_taken, ext_stall;
    logic [1:0]       forward_a_sel, forward_b_sel;
    logic             pc_write, ifid_write, ifid_flush, idex_bubble;
    logic [CNT_W-1:0] stall_cycles, flush_cycles;

    int total = 0;
    int bad   = 0;

    hazard_forward_ctrl #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rs    (id_uses_rs),
        .id_uses_rt    (id_uses_rt),
        .id_dst        (id_dst),
        .id_reg_write  (id_reg_write),
        .id_mem_read   (id_mem_read),
        .branch_taken  (branch_taken),
        .ext_stall     (ext_stall),
        .forward_a_sel (forward_a_sel),
        .forward_b_sel (forward_b_sel),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .ifid_flush    (ifid_flush),
        .idex_bubble   (idex_bubble),
        .stall_cycles  (stall_cycles),
        .flush_cycles  (flush_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt,
                       input logic [4:0] dst,
                       input logic rw, input logic mr);
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rs   = urs;
        id_uses_rt   = urt;
        id_dst       = dst;
        id_reg_write = rw;
        id_mem_read  = mr;
        #1;
    endtask

    task automatic nop();
        put(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic alu(input logic [4:0] dst,
                       input logic [4:0] rs, input logic [4:0] rt);
        put(1'b1, rs, rt, 1'b1, 1'b1, dst, 1'b1, 1'b0);
    endtask

    task automatic lw(input logic [4:0] dst, input logic [4:0] rs);
        put(1'b1, rs, 5'd0, 1'b1, 1'b0, dst, 1'b1, 1'b1);
    endtask

    task automatic drain();
        nop();
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        branch_taken = 1'b0;
        ext_stall = 1'b0;
        nop();
        tick();
        tick();
        chk("rst_fa", 32'(forward_a_sel), 32'd0);
        chk("rst_fb", 32'(forward_b_sel), 32'd0);
        chk("rst_pcw", 32'(pc_write), 32'd1);
        chk("rst_ifw", 32'(ifid_write), 32'd1);
        chk("rst_fl", 32'(ifid_flush), 32'd0);
        chk("rst_bub", 32'(idex_bubble), 32'd0);
        chk("rst_sc", 32'(stall_cycles), 32'd0);
        chk("rst_fc", 32'(flush_cycles), 32'd0);
        rst = 1'b0;

        // EX->EX forward, one-gap WB forward, two-gap none
        alu(5'd3, 5'd1, 5'd2);
        tick();
        alu(5'd8, 5'd3, 5'd4);
        chk("fw_nostall", 32'(pc_write), 32'd1);
        tick();
        chk("fw_mem_a", 32'(forward_a_sel), 32'd2);
        chk("fw_mem_b", 32'(forward_b_sel), 32'd0);
        alu(5'd5, 5'd1, 5'd2);
        tick();
        nop();
        tick();
        alu(5'd10, 5'd9, 5'd5);
        tick();
        chk("fw_wb_a", 32'(forward_a_sel), 32'd0);
        chk("fw_wb_b", 32'(forward_b_sel), 32'd1);
        alu(5'd6, 5'd1, 5'd2);
        tick();
        nop();
        tick();
        tick();
        alu(5'd11, 5'd6, 5'd6);
        tick();
        chk("fw_gap2_a", 32'(forward_a_sel), 32'd0);
        chk("fw_gap2_b", 32'(forward_b_sel), 32'd0);
        alu(5'd7, 5'd1, 5'd2);
        tick();
        alu(5'd7, 5'd1, 5'd1);
        tick();
        alu(5'd12, 5'd7, 5'd7);
        tick();
        chk("newest_a", 32'(forward_a_sel), 32'd2);
        chk("newest_b", 32'(forward_b_sel), 32'd2);

        // load-use: one bubble, then WB forward on both operands
        drain();
        lw(5'd4, 5'd1);
        tick();
        alu(5'd5, 5'd4, 5'd4);
        chk("lu_pcw", 32'(pc_write), 32'd0);
        chk("lu_ifw", 32'(ifid_write), 32'd0);
        chk("lu_bub", 32'(idex_bubble), 32'd1);
        chk("lu_fl", 32'(ifid_flush), 32'd0);
        tick();
        chk("lu_bub_sel", 32'(forward_a_sel), 32'd0);
        chk("lu_rel_pcw", 32'(pc_write), 32'd1);
        chk("lu_rel_bub", 32'(idex_bubble), 32'd0);
        chk("lu_sc", 32'(stall_cycles), 32'd1);
        tick();
        chk("lu_fa", 32'(forward_a_sel), 32'd1);
        chk("lu_fb", 32'(forward_b_sel), 32'd1);

        // branch beats load-use
        drain();
        lw(5'd4, 5'd1);
        tick();
        alu(5'd5, 5'd4, 5'd4);
        branch_taken = 1'b1;
        #1;
        chk("br_fl", 32'(ifid_flush), 32'd1);
        chk("br_bub", 32'(idex_bubble), 32'd1);
        chk("br_pcw", 32'(pc_write), 32'd1);
        tick();
        branch_taken = 1'b0;
        nop();
        chk("br_sc", 32'(stall_cycles), 32'd1);
        chk("br_fc", 32'(flush_cycles), 32'd1);
        chk("br_fa", 32'(forward_a_sel), 32'd0);
        chk("br_fb", 32'(forward_b_sel), 32'd0);

        // $0 producers never forward or stall
        drain();
        alu(5'd0, 5'd1, 5'd2);
        tick();
        lw(5'd0, 5'd1);
        tick();
        alu(5'd13, 5'd0, 5'd0);
        chk("z_pcw", 32'(pc_write), 32'd1);
        chk("z_bub", 32'(idex_bubble), 32'd0);
        tick();
        chk("z_fa", 32'(forward_a_sel), 32'd0);
        chk("z_fb", 32'(forward_b_sel), 32'd0);

        // ext_stall freezes mid-hazard
        drain();
        alu(5'd9, 5'd1, 5'd2);
        tick();
        lw(5'd4, 5'd9);
        tick();
        chk("es_pre_fa", 32'(forward_a_sel), 32'd2);
        alu(5'd5, 5'd4, 5'd4);
        ext_stall = 1'b1;
        #1;
        chk("es_pcw", 32'(pc_write), 32'd0);
        chk("es_ifw", 32'(ifid_write), 32'd0);
        chk("es_bub", 32'(idex_bubble), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("es_fa", 32'(forward_a_sel), 32'd2);
            chk("es_sc", 32'(stall_cycles), 32'd1);
            chk("es_fc", 32'(flush_cycles), 32'd1);
        end
        ext_stall = 1'b0;
        #1;
        chk("es_rel_bub", 32'(idex_bubble), 32'd1);
        chk("es_rel_pcw", 32'(pc_write), 32'd0);
        tick();
        chk("es_rel_sc", 32'(stall_cycles), 32'd2);
        chk("es_rel_fa0", 32'(forward_a_sel), 32'd0);
        tick();
        chk("es_rel_fa", 32'(forward_a_sel), 32'd1);
        chk("es_rel_fb", 32'(forward_b_sel), 32'd1);

        // reset while in STALL
        drain();
        lw(5'd4, 5'd1);
        tick();
        alu(5'd5, 5'd4, 5'd4);
        tick();
        chk("rs_pre_sc", 32'(stall_cycles), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rs_pcw", 32'(pc_write), 32'd1);
        chk("rs_fa", 32'(forward_a_sel), 32'd0);
        chk("rs_fb", 32'(forward_b_sel), 32'd0);
        chk("rs_sc", 32'(stall_cycles), 32'd0);
        chk("rs_fc", 32'(flush_cycles), 32'd0);
        tick();
        chk("rs_empty_fa", 32'(forward_a_sel), 32'd0);

        // saturation at all-ones
        for (int n = 1; n <= 8; n++) begin
            lw(5'd4, 5'd1);
            tick();
            alu(5'd5, 5'd4, 5'd4);
            tick();
            tick();
            if (n >= 6)
                chk("sat_sc", 32'(stall_cycles),
                    (n >= 7) ? 32'd7 : 32'(n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
